// File: rtl/regfile_pkg.sv
// Shared types for the register-file write-port controller: widths, the
// writeback request record and the arbiter's source-select encoding.
package regfile_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_ALU,
        SEL_HOLD,
        SEL_HEAD,
        SEL_LOAD
    } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Small pointer-based FIFO of writeback requests with an explicit count.
// Push and pop may happen in the same cycle, including when full.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic                     pop,
    input  wb_req_t                  din,
    output wb_req_t                  dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t        mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy is governed by the count alone.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between ALU and load writeback,
// queues losing loads, throttles the ALU on starvation and tracks pending writes.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int XLEN       = regfile_pkg::XLEN,
    parameter int NREG       = regfile_pkg::NREG,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     alu_valid,
    input  logic [$clog2(NREG)-1:0]  alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     ld_valid,
    input  logic [$clog2(NREG)-1:0]  ld_rd,
    input  logic [XLEN-1:0]          ld_data,
    output logic                     ld_ready,
    output logic                     alu_stall,
    input  logic                     iss_valid,
    input  logic [$clog2(NREG)-1:0]  iss_rd,
    input  logic [$clog2(NREG)-1:0]  rs1,
    input  logic [$clog2(NREG)-1:0]  rs2,
    output logic                     stall,
    output logic                     rf_we,
    output logic [$clog2(NREG)-1:0]  rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic [NREG-1:0]          pending
);

    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    wb_sel_e         sel;
    wb_req_t         sel_req;
    wb_req_t         fifo_head;
    wb_req_t         hold_req;
    logic            hold_valid;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   fifo_count_nxt;
    logic            fifo_push;
    logic            fifo_pop;
    logic            ld_accept;
    logic            wr_fire;
    logic [SW-1:0]   starve_cnt;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ('{rd: ld_rd, data: ld_data}),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ld_ready  = !fifo_full || (fifo_empty && !alu_valid && !alu_stall);
    assign ld_accept = ld_valid && ld_ready;

    // Throttled head beats everything; a parked ALU result goes next.
    always_comb begin
        sel = SEL_NONE;
        if (alu_stall && !fifo_empty)  sel = SEL_HEAD;
        else if (hold_valid)           sel = SEL_HOLD;
        else if (alu_valid)            sel = SEL_ALU;
        else if (!fifo_empty)          sel = SEL_HEAD;
        else if (ld_accept)            sel = SEL_LOAD;
    end

    always_comb begin
        sel_req = '0;
        case (sel)
            SEL_ALU:  sel_req = '{rd: alu_rd, data: alu_data};
            SEL_HOLD: sel_req = hold_req;
            SEL_HEAD: sel_req = fifo_head;
            SEL_LOAD: sel_req = '{rd: ld_rd, data: ld_data};
            default:  sel_req = '0;
        endcase
    end

    assign fifo_pop       = (sel == SEL_HEAD);
    assign fifo_push      = ld_accept && (sel != SEL_LOAD);
    assign fifo_count_nxt = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    assign wr_fire        = (sel != SEL_NONE) && (sel_req.rd != '0);

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_valid && iss_rd != '0) set_mask = NREG'(1) << iss_rd;
        if (wr_fire)                   clr_mask = NREG'(1) << sel_req.rd;
    end

    assign stall = ((rs1 != '0) && pending[rs1]) || ((rs2 != '0) && pending[rs2]);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            pending    <= '0;
        end else begin
            rf_we   <= wr_fire;
            pending <= (pending & ~clr_mask) | set_mask;
            if (wr_fire) begin
                rf_waddr <= sel_req.rd;
                rf_wdata <= sel_req.data;
            end
        end
    end

    // An ALU result that arrives while it cannot be selected is parked here.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold_valid <= 1'b0;
            hold_req   <= '0;
        end else if (alu_valid && sel != SEL_ALU) begin
            hold_valid <= 1'b1;
            hold_req   <= '{rd: alu_rd, data: alu_data};
        end else if (sel == SEL_HOLD) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            starve_cnt <= '0;
            alu_stall  <= 1'b0;
        end else begin
            if (fifo_pop || fifo_empty)
                starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;

            if (fifo_count_nxt == '0)
                alu_stall <= 1'b0;
            else if (starve_cnt == SW'(STARVE_MAX))
                alu_stall <= 1'b1;
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the 32×32 register file. It shares the file's single write port between the ALU writeback path and the load-unit writeback path. Load results that lose arbitration wait in a small FIFO. A pending-write scoreboard gives decode a read-after-write stall. The block sits between the execute/memory stages and the register file, and drives the file's write-enable, address and data.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, number of architectural registers; address width is $clog2(NREG)
- FIFO_DEPTH, 2, load-result queue depth (power of two, ≥2)
- STARVE_MAX, 4, cycles a queued load may wait before ALU back-pressure is requested

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RESET  in  1  asynchronous, active-high; clears all state
- alu_valid  in  1  ALU result present this cycle; always accepted
- alu_rd  in  AW  ALU destination register
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load result present
- ld_rd  in  AW  load destination register
- ld_data  in  XLEN  load result
- ld_ready  out  1  load result accepted this cycle
- alu_stall  out  1  registered request that upstream withhold ALU results
- iss_valid  in  1  an instruction writing iss_rd issues this cycle
- iss_rd  in  AW  destination register of the issuing instruction
- rs1, rs2  in  AW  source registers of the instruction in decode
- stall  out  1  decode must hold: a source register has a pending write
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  XLEN  register-file write data
- pending  out  NREG  scoreboard bitmask; bit i set means register i has a pending write

## Operation
- **Arbitration, normal mode.** ALU has priority. When alu_valid is high, the ALU result is the selected write.
  - Otherwise, the FIFO head is selected if the FIFO is not empty.
  - Otherwise, an incoming load bypasses the FIFO and is selected directly.
- **Load acceptance.** ld_ready = (FIFO not full) || (FIFO empty && !alu_valid && !starve). This is combinational.
  - A load that is accepted and not selected is pushed into the FIFO.
  - Push and pop in the same cycle are allowed when the FIFO is full.
- **Starvation.** A counter runs while the FIFO head is waiting and is not selected. It resets on every pop.
  - When the count reaches STARVE_MAX, alu_stall is set the next cycle. It stays set until the FIFO is empty.
  - While alu_stall is set, the FIFO head has priority over the ALU.
  - An alu_valid presented in that state is a protocol error. The ALU result is still written one cycle later, and the head still wins.
- **x0 handling.** A selected write to register 0 is consumed without a write: rf_we stays 0 and the scoreboard is unchanged. An issue to x0 does not set a pending bit.
- **Scoreboard.**
  - iss_valid with iss_rd≠0 sets pending[iss_rd].
  - A selected write with rd≠0 clears pending[rd].
  - If a set and a clear hit the same register in the same cycle, the set wins.
- **Stall.** stall = (rs1≠0 && pending[rs1]) || (rs2≠0 && pending[rs2]). This is combinational from the registered pending vector. There is no forwarding.
- **Write ordering.** When both sources present the same cycle, the ALU write is committed first. Preventing write-after-write conflicts between the two sources is the issuer's job, done by honouring stall.

## Timing
- Selected write appears on rf_we/rf_waddr/rf_wdata one cycle after selection. All three outputs are registered.
  - ALU-to-regfile latency is 1 cycle.
  - Load bypass latency is 1 cycle.
  - A queued load takes 1 cycle after the pop.
- A pending bit clears on the same edge that loads rf_we. stall drops in the cycle the write is visible on the rf_* outputs.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, alu_stall=0, FIFO empty, starvation count 0. As a result, stall=0 and ld_ready=1 during reset.
- RESET asserted mid-operation discards queued loads and pending bits immediately. No write is committed after the asynchronous clear.

## Structure
- Package regfile_pkg holds:
  - XLEN, NREG and the derived AW
  - typedef wb_req_t {rd, data}, shared by the FIFO and the arbiter
- Sub-module wb_fifo: FIFO of wb_req_t, FIFO_DEPTH deep.
  - Pointer-based, with an explicit count.
  - Outputs full and empty; allows simultaneous push and pop.
- The arbiter, starvation counter, scoreboard and output registers live in regfile_wb_arbiter.

## Test plan
- **Reset then single writes.** Release RESET. Send alu_valid with rd=5, data=0xA5A5A5A5 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xA5A5A5A5. With the FIFO empty, ld_valid with rd=7 gives the same 1-cycle latency.
- **Collision.** alu (rd=3, 0x11) and ld (rd=4, 0x22) in the same cycle → ld_ready=1. Cycle +1 writes r3; cycle +2 writes r4; the FIFO returns to empty.
- **Back-pressure and starvation.** Hold alu_valid continuously and send 3 loads → ld_ready=0 after two loads are queued. alu_stall=1 after STARVE_MAX=4 waiting cycles. The head then drains ahead of the ALU, and alu_stall clears when the FIFO is empty.
- **Scoreboard.** Issue rd=9, then put rs1=9 in decode → stall=1. The ALU writes r9 → stall=0 in the cycle rf_we shows r9. Issue rd=9 in the same cycle the r9 write is selected → pending[9] remains 1.
- **x0.** Issue iss_rd=0, then alu rd=0 and ld rd=0 → pending=0, rf_we never asserted, ld_ready=1.
- **Reset mid-queue.** Two loads queued and pending=0x0000_0600; assert RESET → pending=0, rf_we=0, FIFO empty in the same cycle. No stale write appears after release.
